// File: rtl/pix_pkg.sv
// Shared pixel-stream constants and types for the window generator.
package pix_pkg;

  localparam int unsigned N_DEF     = 8;    // default pixel width
  localparam int unsigned K         = 9;    // taps per 3x3 window
  localparam int unsigned IMG_W_DEF = 640;  // default pixels per line
  localparam int unsigned IMG_H_DEF = 480;  // default lines per frame

  typedef logic [N_DEF-1:0] pixel_t;

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out bundle between the stream source, the window
// generator (master, producer of windows) and the filter (slave).
interface sliding_window_gen_if #(
  parameter int unsigned N = 8
) ();

  logic         pix_valid;
  logic [N-1:0] pix_in;
  logic         win_valid;
  logic [N-1:0] sw_pixel_1;
  logic [N-1:0] sw_pixel_2;
  logic [N-1:0] sw_pixel_3;
  logic [N-1:0] sw_pixel_4;
  logic [N-1:0] sw_pixel_5;
  logic [N-1:0] sw_pixel_6;
  logic [N-1:0] sw_pixel_7;
  logic [N-1:0] sw_pixel_8;
  logic [N-1:0] sw_pixel_9;
  logic         frame_done;
  logic         busy;

  modport master (
    input  pix_valid, pix_in,
    output win_valid,
    output sw_pixel_1, sw_pixel_2, sw_pixel_3,
    output sw_pixel_4, sw_pixel_5, sw_pixel_6,
    output sw_pixel_7, sw_pixel_8, sw_pixel_9,
    output frame_done, busy
  );

  modport slave (
    output pix_valid, pix_in,
    input  win_valid,
    input  sw_pixel_1, sw_pixel_2, sw_pixel_3,
    input  sw_pixel_4, sw_pixel_5, sw_pixel_6,
    input  sw_pixel_7, sw_pixel_8, sw_pixel_9,
    input  frame_done, busy
  );

endinterface

// File: rtl/line_buffer.sv
// One video line of storage; the old word at addr is visible combinationally
// while the new word is written on the same edge (read-before-write).
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned N     = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rd_data_c
);

  logic [N-1:0] mem [DEPTH];

  assign rd_data_c = mem[addr];

  // Contents are never cleared; validity is gated by the frame counters.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register array
// turn a raster pixel stream into one full-frame-interior window per pixel.
module sliding_window_gen
  import pix_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,   // active-high synchronous reset
  sliding_window_gen_if.master bus
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          in_window;
  logic          frame_start;
  logic [N-1:0]  lb0_rd;
  logic [N-1:0]  lb1_rd;
  logic [N-1:0]  tap [K];
  logic          win_valid_q;
  logic          frame_done_q;
  logic          busy_q;

  assign accept      = bus.pix_valid;
  assign col_last    = (col == COL_LAST);
  assign row_last    = (row == ROW_LAST);
  assign in_window   = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_start = (row == '0) && (col == '0);

  // LB0 holds row r-1; its old word cascades into LB1 (row r-2).
  line_buffer #(.DEPTH(IMG_W), .N(N), .AW(CW)) u_lb0 (
    .clk       (clk),
    .we        (accept),
    .addr      (col),
    .wdata     (bus.pix_in),
    .rd_data_c (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .N(N), .AW(CW)) u_lb1 (
    .clk       (clk),
    .we        (accept),
    .addr      (col),
    .wdata     (lb0_rd),
    .rd_data_c (lb1_rd)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window array: shift left, new right column is {row r-2, row r-1, row r}.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tap <= '{default: '0};
    end else if (accept) begin
      tap[0] <= tap[1];
      tap[1] <= tap[2];
      tap[2] <= lb1_rd;
      tap[3] <= tap[4];
      tap[4] <= tap[5];
      tap[5] <= lb0_rd;
      tap[6] <= tap[7];
      tap[7] <= tap[8];
      tap[8] <= bus.pix_in;
    end
  end

  // Status flags; stale columns at c<2 and partial rows at r<2 are masked.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      win_valid_q  <= accept && in_window;
      frame_done_q <= accept && row_last && col_last;
      if (accept && frame_start) begin
        busy_q <= 1'b1;
      end else if (frame_done_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.sw_pixel_1 = tap[0];
  assign bus.sw_pixel_2 = tap[1];
  assign bus.sw_pixel_3 = tap[2];
  assign bus.sw_pixel_4 = tap[3];
  assign bus.sw_pixel_5 = tap[4];
  assign bus.sw_pixel_6 = tap[5];
  assign bus.sw_pixel_7 = tap[6];
  assign bus.sw_pixel_8 = tap[7];
  assign bus.sw_pixel_9 = tap[8];

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen: a 4x4 instance for the frame
// scenarios and a 5x3 instance for the random-stream sweep.
module tb_sliding_window_gen;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_pass;

  sliding_window_gen_if #(.N(8)) ifa ();
  sliding_window_gen_if #(.N(8)) ifb ();

  sliding_window_gen #(.N(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ifa.master)
  );

  sliding_window_gen #(.N(8), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed windows, frame_done flags and the pixel that produced each.
  logic [71:0] winq_a [$];
  logic        fdq_a  [$];
  logic [7:0]  srcq_a [$];
  logic [71:0] winq_b [$];
  logic        fdq_b  [$];
  logic        acc_a;
  logic [7:0]  pix_a;
  int          idle_hits;
  int          fd_orphan;
  int          busy_low;
  bit          busy_armed;

  logic [71:0] taps_a;
  logic [71:0] taps_b;
  assign taps_a = {ifa.sw_pixel_1, ifa.sw_pixel_2, ifa.sw_pixel_3,
                   ifa.sw_pixel_4, ifa.sw_pixel_5, ifa.sw_pixel_6,
                   ifa.sw_pixel_7, ifa.sw_pixel_8, ifa.sw_pixel_9};
  assign taps_b = {ifb.sw_pixel_1, ifb.sw_pixel_2, ifb.sw_pixel_3,
                   ifb.sw_pixel_4, ifb.sw_pixel_5, ifb.sw_pixel_6,
                   ifb.sw_pixel_7, ifb.sw_pixel_8, ifb.sw_pixel_9};

  always @(posedge clk) begin
    acc_a <= ifa.pix_valid & ~rst_a;
    pix_a <= ifa.pix_in;
  end

  always @(negedge clk) begin
    if (ifa.win_valid) begin
      winq_a.push_back(taps_a);
      fdq_a.push_back(ifa.frame_done);
      srcq_a.push_back(pix_a);
      if (!acc_a) idle_hits++;
    end
    if (ifa.frame_done && !ifa.win_valid) fd_orphan++;
    if (ifb.win_valid) begin
      winq_b.push_back(taps_b);
      fdq_b.push_back(ifb.frame_done);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [71:0] mkwin(input int p1, input int p2, input int p3,
                                        input int p4, input int p5, input int p6,
                                        input int p7, input int p8, input int p9);
    return {8'(p1), 8'(p2), 8'(p3), 8'(p4), 8'(p5), 8'(p6), 8'(p7), 8'(p8), 8'(p9)};
  endfunction

  function automatic logic [71:0] win_a(input int idx);
    return (idx < winq_a.size()) ? winq_a[idx] : '1;
  endfunction

  function automatic logic [71:0] win_b(input int idx);
    return (idx < winq_b.size()) ? winq_b[idx] : '1;
  endfunction

  function automatic int fd_count_a();
    int cnt = 0;
    foreach (fdq_a[i]) if (fdq_a[i]) cnt++;
    return cnt;
  endfunction

  function automatic logic [31:0] src4_a();
    logic [31:0] v = '1;
    if (srcq_a.size() >= 4) v = {srcq_a[0], srcq_a[1], srcq_a[2], srcq_a[3]};
    return v;
  endfunction

  function automatic logic [3:0] fd4_a(input int base);
    logic [3:0] v = '1;
    if (fdq_a.size() >= base + 4) v = {fdq_a[base], fdq_a[base+1], fdq_a[base+2], fdq_a[base+3]};
    return v;
  endfunction

  task automatic clear_a();
    winq_a.delete();
    fdq_a.delete();
    srcq_a.delete();
    idle_hits  = 0;
    fd_orphan  = 0;
    busy_low   = 0;
    busy_armed = 1'b0;
  endtask

  // Stream n consecutive values from first; optionally an idle cycle after each.
  task automatic feed_a(input int first, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_armed && !ifa.busy) busy_low++;
      ifa.pix_valid = 1'b1;
      ifa.pix_in    = 8'(first + i);
      busy_armed    = 1'b1;
      if (gaps) begin
        @(negedge clk);
        if (!ifa.busy) busy_low++;
        ifa.pix_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.pix_valid = 1'b0;
    end
  endtask

  task automatic check_basic_windows(input string tag);
    check({tag, "_count"}, 128'(winq_a.size()), 128'd4);
    check({tag, "_w0"}, 128'(win_a(0)), 128'(mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    check({tag, "_w1"}, 128'(win_a(1)), 128'(mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11)));
    check({tag, "_w2"}, 128'(win_a(2)), 128'(mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14)));
    check({tag, "_w3"}, 128'(win_a(3)), 128'(mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)));
    check({tag, "_src"}, 128'(src4_a()), 128'({8'd10, 8'd11, 8'd14, 8'd15}));
    check({tag, "_fd_flags"}, 128'(fd4_a(0)), 128'(4'b0001));
  endtask

  int fr [$];

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    ifa.pix_valid = 1'b0;
    ifa.pix_in    = '0;
    ifb.pix_valid = 1'b0;
    ifb.pix_in    = '0;
    rst_a         = 1'b1;
    rst_b         = 1'b1;
    clear_a();

    // Reset state
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("rst_win_valid", 128'(ifa.win_valid), 128'd0);
    check("rst_frame_done", 128'(ifa.frame_done), 128'd0);
    check("rst_busy", 128'(ifa.busy), 128'd0);
    check("rst_taps", 128'(taps_a), 128'd0);

    // Basic frame, back-to-back pixels
    clear_a();
    feed_a(0, 16, 1'b0);
    idle_a(3);
    check_basic_windows("basic");
    check("basic_fd_pulses", 128'(fd_count_a()), 128'd1);
    check("basic_fd_orphan", 128'(fd_orphan), 128'd0);
    check("basic_busy_during", 128'(busy_low), 128'd0);
    check("basic_busy_after", 128'(ifa.busy), 128'd0);

    // Same frame with an idle cycle after every pixel
    clear_a();
    feed_a(0, 16, 1'b1);
    idle_a(3);
    check_basic_windows("stall");
    check("stall_idle_valid", 128'(idle_hits), 128'd0);
    check("stall_busy_during", 128'(busy_low), 128'd0);

    // Two frames with no gap
    clear_a();
    feed_a(0, 16, 1'b0);
    feed_a(100, 16, 1'b0);
    check("b2b_busy_during", 128'(busy_low), 128'd0);
    idle_a(3);
    check("b2b_count", 128'(winq_a.size()), 128'd8);
    check("b2b_f1_w0", 128'(win_a(0)), 128'(mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    check("b2b_f2_w0", 128'(win_a(4)), 128'(mkwin(100, 101, 102, 104, 105, 106, 108, 109, 110)));
    check("b2b_f2_w1", 128'(win_a(5)), 128'(mkwin(101, 102, 103, 105, 106, 107, 109, 110, 111)));
    check("b2b_f2_w3", 128'(win_a(7)), 128'(mkwin(105, 106, 107, 109, 110, 111, 113, 114, 115)));
    check("b2b_fd_flags", 128'({fd4_a(0), fd4_a(4)}), 128'(8'b0001_0001));

    // Reset after pixel 9, then a fresh frame
    clear_a();
    feed_a(0, 10, 1'b0);
    @(negedge clk);
    check("pre_rst_taps_nonzero", 128'(taps_a != '0), 128'd1);
    ifa.pix_valid = 1'b0;
    rst_a         = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst_win_valid", 128'(ifa.win_valid), 128'd0);
    check("midrst_busy", 128'(ifa.busy), 128'd0);
    check("midrst_taps", 128'(taps_a), 128'd0);
    clear_a();
    feed_a(50, 16, 1'b0);
    idle_a(3);
    check("midrst_count", 128'(winq_a.size()), 128'd4);
    check("midrst_w0", 128'(win_a(0)), 128'(mkwin(50, 51, 52, 54, 55, 56, 58, 59, 60)));
    check("midrst_w3", 128'(win_a(3)), 128'(mkwin(55, 56, 57, 59, 60, 61, 63, 64, 65)));
    check("midrst_fd_flags", 128'(fd4_a(0)), 128'(4'b0001));

    // 5x3 instance, random stream against a frame model
    for (int i = 0; i < 15; i++) fr.push_back(int'($urandom_range(0, 255)));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ifb.pix_valid = 1'b1;
      ifb.pix_in    = 8'(fr[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifb.pix_valid = 1'b0;
    end
    check("sweep_count", 128'(winq_b.size()), 128'd3);
    for (int c = 2; c < 5; c++) begin
      check($sformatf("sweep_w%0d", c - 2), 128'(win_b(c - 2)),
            128'(mkwin(fr[c-2], fr[c-1], fr[c], fr[5+c-2], fr[5+c-1], fr[5+c],
                       fr[10+c-2], fr[10+c-1], fr[10+c])));
      check($sformatf("sweep_fd%0d", c - 2),
            128'((c - 2 < fdq_b.size()) ? fdq_b[c-2] : 1'bx), 128'(c == 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
